ffn_frame_buffer: RTL and testbench

//  Ping-pong feature-map buffer feeding the FFN matrix-multiply accumulator.

---
 rtl/ffn_frame_buffer_pkg.sv | 24 ++
 rtl/ffn_buf_bank.sv | 44 ++++
 rtl/ffn_frame_buffer.sv | 176 +++++++++++++++++
 tb/tb_ffn_frame_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ffn_frame_buffer_pkg.sv
//==============================================================================
// Module : ffn_frame_buffer_pkg
// Brief  : Shared network sizing constants and write-FSM encodings for the
//          FFN ping-pong frame buffer.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package ffn_frame_buffer_pkg;

  localparam int FFN_IN_BITWIDTH  = 7;
  localparam int FM_ADDR_BITWIDTH = 5;
  localparam int NP_MAX_COUNT     = 63;
  localparam int NUM_MM_BUFFER    = 2;

  typedef logic [1:0] wr_state_t;

  localparam wr_state_t c_ST_IDLE  = 2'd0;
  localparam wr_state_t c_ST_FILL  = 2'd1;
  localparam wr_state_t c_ST_STALL = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ffn_buf_bank.sv
//==============================================================================
// Module : ffn_buf_bank
// Brief  : One DEPTH x DATA_W frame bank, single write port, registered read.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module ffn_buf_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Storage array is deliberately left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/ffn_frame_buffer.sv
//==============================================================================
// Module : ffn_frame_buffer
// Brief  : Ping-pong feature-map buffer between conv/pool output and the FFN
//          accumulator. Optional checker enabled by FFN_BUF_OVR_CHK_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module ffn_frame_buffer
  import ffn_frame_buffer_pkg::*;
#(
  parameter int DATA_W = FFN_IN_BITWIDTH + 1,
  parameter int DEPTH  = NP_MAX_COUNT + 1,
  parameter int ADDR_W = FM_ADDR_BITWIDTH + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_pix_in,
  input  logic              i_pix_valid,
  output logic              o_pix_ready,
  input  logic [ADDR_W-1:0] i_buf_addr,
  output logic [DATA_W-1:0] o_feature_pixel,
  output logic              o_frame_rdy,
  input  logic              i_frame_release,
  output logic              o_ovr_err
);

  wr_state_t                 r_state;
  wr_state_t                 w_state_nxt;
  logic                      r_wr_bank;
  logic                      r_rd_bank;
  logic                      r_rd_sel;
  logic [ADDR_W-1:0]         r_wr_ptr;
  logic [NUM_MM_BUFFER-1:0]  r_full;
  logic [NUM_MM_BUFFER-1:0]  w_full_nxt;
  logic [NUM_MM_BUFFER-1:0]  w_bank_we;
  logic [DATA_W-1:0]         w_rd_data [NUM_MM_BUFFER];
  logic                      w_pix_ready;
  logic                      w_xfer;
  logic                      w_last;
  logic                      w_release;

  assign w_xfer    = i_pix_valid && w_pix_ready;
  assign w_last    = (r_wr_ptr == ADDR_W'(DEPTH - 1));
  assign w_release = i_frame_release && r_full[r_rd_bank];

  // Write FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write FSM: next state. The stall decision looks at the registered full
  // flag, so a release landing on the same edge still costs one stall cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  w_state_nxt = c_ST_FILL;
      c_ST_FILL: begin
        if (w_xfer && w_last && r_full[~r_wr_bank]) begin
          w_state_nxt = c_ST_STALL;
        end
      end
      c_ST_STALL: begin
        if (!r_full[r_wr_bank]) begin
          w_state_nxt = c_ST_FILL;
        end
      end
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    w_pix_ready = 1'b0;
    if (r_state == c_ST_FILL) begin
      w_pix_ready = 1'b1;
    end
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_release) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
    if (w_xfer && w_last) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_full    <= '0;
    end else begin
      r_rd_sel <= r_rd_bank;
      r_full   <= w_full_nxt;
      if (w_xfer) begin
        if (w_last) begin
          r_wr_ptr  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  for (genvar b = 0; b < NUM_MM_BUFFER; b++) begin : g_bank
    assign w_bank_we[b] = w_xfer && (r_wr_bank == 1'(b));

    ffn_buf_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_bank_we[b]),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (i_pix_in),
      .i_rd_addr (i_buf_addr),
      .o_rd_data (w_rd_data[b])
    );
  end

  // Both banks read every cycle; the delayed bank select picks the one that
  // was the read bank when the address was sampled.
  assign o_feature_pixel = w_rd_data[r_rd_sel];
  assign o_frame_rdy     = r_full[r_rd_bank];
  assign o_pix_ready     = w_pix_ready;

`ifdef FFN_BUF_OVR_CHK_EN
  logic              r_ovr_err;
  logic [ADDR_W:0]   r_stall_cnt;
  logic              w_stall_valid;
  logic              w_addr_oob;

  assign w_stall_valid = (r_state == c_ST_STALL) && i_pix_valid;
  assign w_addr_oob    = ({1'b0, i_buf_addr} >= (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_ovr_err   <= 1'b0;
    end else begin
      if (!w_stall_valid) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != (ADDR_W+1)'(DEPTH)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if ((i_frame_release && !o_frame_rdy) ||
          (w_addr_oob && o_frame_rdy) ||
          (w_stall_valid && (r_stall_cnt == (ADDR_W+1)'(DEPTH)))) begin
        r_ovr_err <= 1'b1;
      end
    end
  end

  assign o_ovr_err = r_ovr_err;
`else
  assign o_ovr_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ffn_frame_buffer.sv
//==============================================================================
// Module : tb_ffn_frame_buffer
// Brief  : Directed bench for ffn_frame_buffer with a frame-queue reference.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_ffn_frame_buffer;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_pix_in = '0;
  logic       i_pix_valid = 1'b0;
  logic       o_pix_ready;
  logic [5:0] i_buf_addr = '0;
  logic [7:0] o_feature_pixel;
  logic       o_frame_rdy;
  logic       i_frame_release = 1'b0;
  logic       o_ovr_err;

  int checks = 0;
  int errors = 0;

  ffn_frame_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_pix_in        (i_pix_in),
    .i_pix_valid     (i_pix_valid),
    .o_pix_ready     (o_pix_ready),
    .i_buf_addr      (i_buf_addr),
    .o_feature_pixel (o_feature_pixel),
    .o_frame_rdy     (o_frame_rdy),
    .i_frame_release (i_frame_release),
    .o_ovr_err       (o_ovr_err)
  );

  always #5 clk = ~clk;

  // Reference: completed frames kept oldest-first in one flat queue; the
  // buffer holds two frames, a full pair forces a stall until one is freed.
  logic [7:0] fq [$];
  logic [7:0] cur [DEPTH];
  int         m_cnt = 0;
  int         m_n   = 0;
  int         m_svc = 0;
  bit         m_idle  = 1'b1;
  bit         m_stall = 1'b0;
  bit         m_ovr   = 1'b0;
  bit         m_xfer;
  bit         fp_ok  = 1'b1;
  logic [7:0] exp_fp = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      fq.delete();
      m_cnt = 0; m_svc = 0;
      m_idle = 1'b1; m_stall = 1'b0; m_ovr = 1'b0;
      fp_ok = 1'b1; exp_fp = '0;
    end else begin
      m_n    = fq.size() / DEPTH;
      m_xfer = i_pix_valid && !m_idle && !m_stall;
      if (m_n > 0) begin
        exp_fp = fq[i_buf_addr];
        fp_ok  = 1'b1;
      end else begin
        fp_ok = 1'b0;
      end
      if (i_frame_release && m_n == 0) m_ovr = 1'b1;
      m_svc = (m_stall && i_pix_valid) ? m_svc + 1 : 0;
      if (m_svc > DEPTH) m_ovr = 1'b1;
      if (m_stall && m_n < 2) m_stall = 1'b0;
      m_idle = 1'b0;
      if (m_xfer) begin
        cur[m_cnt] = i_pix_in;
        m_cnt++;
        if (m_cnt == DEPTH) begin
          for (int k = 0; k < DEPTH; k++) fq.push_back(cur[k]);
          m_cnt = 0;
          if (m_n == 1) m_stall = 1'b1;
        end
      end
      if (i_frame_release && m_n > 0) begin
        repeat (DEPTH) void'(fq.pop_front());
      end
    end
  end

  initial forever begin
    bit exp_ovr;
    @(negedge clk);
`ifdef FFN_BUF_OVR_CHK_EN
    exp_ovr = m_ovr;
`else
    exp_ovr = 1'b0;
`endif
    checks++;
    if (o_pix_ready !== (!m_idle && !m_stall)) begin
      errors++;
      $display("FAIL cmp_pix_ready t=%0t actual=%b expected=%b", $time, o_pix_ready, !m_idle && !m_stall);
    end
    checks++;
    if (o_frame_rdy !== (fq.size() > 0)) begin
      errors++;
      $display("FAIL cmp_frame_rdy t=%0t actual=%b expected=%b", $time, o_frame_rdy, fq.size() > 0);
    end
    checks++;
    if (o_ovr_err !== exp_ovr) begin
      errors++;
      $display("FAIL cmp_ovr_err t=%0t actual=%b expected=%b", $time, o_ovr_err, exp_ovr);
    end
    if (fp_ok) begin
      checks++;
      if (o_feature_pixel !== exp_fp) begin
        errors++;
        $display("FAIL cmp_feature_pixel t=%0t actual=%0d expected=%0d", $time, o_feature_pixel, exp_fp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] addr, input logic rel);
    i_buf_addr = addr;
    i_frame_release = rel;
    @(posedge clk);
    @(negedge clk);
    i_frame_release = 1'b0;
  endtask

  task automatic send_px(input logic [7:0] v, input logic rel);
    int n = 0;
    i_pix_valid = 1'b1;
    i_pix_in = v;
    while (!o_pix_ready && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!o_pix_ready) chk("ready_timeout", int'(o_pix_ready), 1);
    i_frame_release = rel;
    @(posedge clk);
    @(negedge clk);
    i_frame_release = 1'b0;
  endtask

  task automatic stream(input int base, input int num);
    for (int i = 0; i < num; i++) send_px(8'(base + i), 1'b0);
    i_pix_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    i_pix_valid = 1'b0;
    i_frame_release = 1'b0;
    i_buf_addr = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pix_ready", int'(o_pix_ready), 0);
    chk("rst_frame_rdy", int'(o_frame_rdy), 0);
    chk("rst_feature_pixel", int'(o_feature_pixel), 0);
    chk("rst_ovr_err", int'(o_ovr_err), 0);
    #1;
    rst_n = 1'b1;
    chk("idle_pix_ready", int'(o_pix_ready), 0);
    @(posedge clk);
    @(negedge clk);
    chk("fill_pix_ready", int'(o_pix_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // 1: one frame, ready rises after last pixel, addr 5 reads back 5
    stream(0, 64);
    chk("t1_frame_rdy", int'(o_frame_rdy), 1);
    step(6'd5, 1'b0);
    chk("t1_pix5", int'(o_feature_pixel), 5);

    // 2: two frames without release stall; release reopens two cycles later
    do_reset();
    stream(0, 128);
    chk("t2_stall_ready", int'(o_pix_ready), 0);
    chk("t2_frame_rdy", int'(o_frame_rdy), 1);
    step(6'd0, 1'b1);
    chk("t2_ready_p1", int'(o_pix_ready), 0);
    chk("t2_rdy_p1", int'(o_frame_rdy), 1);
    step(6'd0, 1'b0);
    chk("t2_ready_p2", int'(o_pix_ready), 1);
    chk("t2_bank1_px0", int'(o_feature_pixel), 64);

    // 3: frame order A then B across a release
    do_reset();
    stream(0, 64);
    stream(100, 64);
    step(6'd0, 1'b0);
    chk("t3_a0", int'(o_feature_pixel), 0);
    step(6'd0, 1'b1);
    chk("t3_a0_rel", int'(o_feature_pixel), 0);
    step(6'd0, 1'b0);
    chk("t3_b0", int'(o_feature_pixel), 100);

    // 4: final write of bank 1 coincides with release of bank 0
    do_reset();
    stream(0, 64);
    for (int i = 64; i < 127; i++) send_px(8'(i), 1'b0);
    send_px(8'd127, 1'b1);
    i_pix_valid = 1'b0;
    chk("t4_frame_rdy", int'(o_frame_rdy), 1);
    chk("t4_stall1", int'(o_pix_ready), 0);
    step(6'd63, 1'b0);
    chk("t4_ready", int'(o_pix_ready), 1);
    chk("t4_px127", int'(o_feature_pixel), 127);
    stream(128, 64);
    step(6'd0, 1'b0);
    chk("t4_px64", int'(o_feature_pixel), 64);
    step(6'd0, 1'b1);
    step(6'd0, 1'b0);
    chk("t4_px128", int'(o_feature_pixel), 128);

    // 5: reset in the middle of a frame drops everything
    do_reset();
    stream(0, 64);
    stream(64, 30);
    do_reset();
    stream(50, 64);
    chk("t5_frame_rdy", int'(o_frame_rdy), 1);
    step(6'd0, 1'b0);
    chk("t5_px0", int'(o_feature_pixel), 50);
    step(6'd63, 1'b0);
    chk("t5_px63", int'(o_feature_pixel), 113);

    // 6: release with no frame ready
    do_reset();
    step(6'd0, 1'b1);
`ifdef FFN_BUF_OVR_CHK_EN
    chk("t6_ovr_set", int'(o_ovr_err), 1);
    repeat (3) step(6'd0, 1'b0);
    chk("t6_ovr_hold", int'(o_ovr_err), 1);
`else
    chk("t6_ovr_off", int'(o_ovr_err), 0);
    repeat (3) step(6'd0, 1'b0);
    chk("t6_ovr_off_hold", int'(o_ovr_err), 0);
`endif
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
